// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and small op-decode helpers. MDU_ACC_EN selects the multiply-accumulate ops.
package mdu_pkg;

  localparam logic [2:0] MDU_MULT  = 3'b000;
  localparam logic [2:0] MDU_MULTU = 3'b001;
  localparam logic [2:0] MDU_DIV   = 3'b010;
  localparam logic [2:0] MDU_DIVU  = 3'b011;
  localparam logic [2:0] MDU_MADD  = 3'b100;
  localparam logic [2:0] MDU_MADDU = 3'b101;
  localparam logic [2:0] MDU_MSUB  = 3'b110;
  localparam logic [2:0] MDU_MSUBU = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } mdu_state_t;

  // HI:LO concatenation width for a given operand width.
  function automatic int prod_width(input int w);
    return 2 * w;
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic op_is_acc(input logic [2:0] op);
    return (op == MDU_MADD) || (op == MDU_MADDU) ||
           (op == MDU_MSUB) || (op == MDU_MSUBU);
  endfunction

  function automatic logic op_is_sub(input logic [2:0] op);
    return (op == MDU_MSUB) || (op == MDU_MSUBU);
  endfunction

  function automatic logic op_is_unsigned(input logic [2:0] op);
    return (op == MDU_MULTU) || (op == MDU_DIVU) ||
           (op == MDU_MADDU) || (op == MDU_MSUBU);
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Iterative restoring divider, one quotient bit per cycle. `go` loads the
// operands; `done` is high during the last iteration; quo/rem carry the sign fix.
module mdu_div_core
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
);

  localparam int CW = $clog2(WIDTH);

  logic             run;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] dvd_raw;
  logic             neg_quo;
  logic             neg_rem;
  logic             div_zero;

  logic [WIDTH-1:0] dvd_mag_in;
  logic [WIDTH-1:0] dvs_mag_in;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // Two's-complement negation of MIN yields MIN, which is the correct
  // unsigned magnitude 2^(WIDTH-1).
  assign dvd_mag_in = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign dvs_mag_in = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_mag};

  always_ff @(posedge clk) begin
    if (reset) begin
      run      <= 1'b0;
      cnt      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_mag  <= '0;
      dvd_raw  <= '0;
      neg_quo  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
    end else if (go) begin
      run      <= 1'b1;
      cnt      <= CW'(WIDTH - 1);
      rem_q    <= '0;
      quo_q    <= dvd_mag_in;
      dvs_mag  <= dvs_mag_in;
      dvd_raw  <= dividend;
      neg_quo  <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      neg_rem  <= is_signed && dividend[WIDTH-1];
      div_zero <= (divisor == '0);
    end else if (run) begin
      // A clear borrow bit means the trial subtraction fits: keep it.
      if (!trial[WIDTH]) begin
        rem_q <= trial[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_q <= shifted[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
      end
      cnt <= cnt - CW'(1);
      if (cnt == '0) run <= 1'b0;
    end
  end

  assign done = run && (cnt == '0);

  // Divide-by-zero returns all ones and the untouched dividend, regardless of sign.
  assign quo = div_zero ? '1      : (neg_quo ? -quo_q : quo_q);
  assign rem = div_zero ? dvd_raw : (neg_rem ? -rem_q : rem_q);

endmodule

// File: rtl/mdu_iter.sv
// Multiply/divide unit with HI/LO, fixed-latency multiply and iterative divide.
// Define MDU_ACC_EN to enable madd/maddu/msub/msubu (op[2]==1).
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] data_w,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int PW    = prod_width(WIDTH);
  localparam int CNT_W = $clog2(MUL_LAT + 1);

  mdu_state_t       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [PW-1:0]    prod_q, prod_n;
  logic [WIDTH-1:0] hi_n, lo_n;

  logic             op_legal;
  logic             accept;
  logic             div_go;
  logic             div_done;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_rem;
  logic [PW-1:0]    ext_a, ext_b;
  logic [PW-1:0]    product;
  logic [PW-1:0]    mul_result;

`ifdef MDU_ACC_EN
  assign op_legal = 1'b1;
`else
  assign op_legal = !op_is_acc(op);
`endif

  assign accept = start && !req && (state == IDLE) && op_legal;

  // Sign- or zero-extend to 2W so the truncated 2W product is correct either way.
  assign ext_a   = op_is_unsigned(op) ? {{WIDTH{1'b0}}, in_a} : {{WIDTH{in_a[WIDTH-1]}}, in_a};
  assign ext_b   = op_is_unsigned(op) ? {{WIDTH{1'b0}}, in_b} : {{WIDTH{in_b[WIDTH-1]}}, in_b};
  assign product = ext_a * ext_b;

`ifdef MDU_ACC_EN
  // Accumulate uses HI/LO as they stand at the accept edge.
  always_comb begin
    mul_result = product;
    if (op_is_acc(op))
      mul_result = op_is_sub(op) ? ({hi, lo} - product) : ({hi, lo} + product);
  end
`else
  assign mul_result = product;
`endif

  mdu_div_core #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .reset     (reset),
    .go        (div_go),
    .is_signed (!op_is_unsigned(op)),
    .dividend  (in_a),
    .divisor   (in_b),
    .done      (div_done),
    .quo       (div_quo),
    .rem       (div_rem)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      prod_q <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      prod_q <= prod_n;
      hi     <= hi_n;
      lo     <= lo_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    prod_n  = prod_q;
    hi_n    = hi;
    lo_n    = lo;
    div_go  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (op_is_div(op)) begin
            div_go  = 1'b1;
            state_n = DIV;
          end else begin
            prod_n  = mul_result;
            cnt_n   = CNT_W'(MUL_LAT - 1);
            state_n = MUL;
          end
        end else if (!req && !start) begin
          if (mthi) hi_n = data_w;
          if (mtlo) lo_n = data_w;
        end
      end
      MUL: begin
        if (cnt == '0) begin
          hi_n    = prod_q[PW-1:WIDTH];
          lo_n    = prod_q[WIDTH-1:0];
          state_n = IDLE;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      DIV: begin
        if (div_done) state_n = FIX;
      end
      FIX: begin
        hi_n    = div_rem;
        lo_n    = div_quo;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter (WIDTH=32, MUL_LAT=5) with hand-computed results;
// covers the MDU_ACC_EN build and the default build.
module tb_mdu_iter;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic [31:0] data_w = '0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int vectors = 0;
  int miscompares = 0;
  int n;

  always #5 clk = ~clk;

  mdu_iter #(.WIDTH(32), .MUL_LAT(5)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .start  (start),
    .op     (op),
    .in_a   (in_a),
    .in_b   (in_b),
    .mthi   (mthi),
    .mtlo   (mtlo),
    .data_w (data_w),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents a start for one cycle; returns at the negedge after the accept edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op = o; in_a = a; in_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts negedges with busy high; bounded so a stuck busy still terminates.
  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);

    issue(MDU_MULT, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n);
    chk("mult_lat", 32'(n), 32'd5);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);

    issue(MDU_MULTU, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n);
    chk("multu_hi", hi, 32'h0000_0002);
    chk("multu_lo", lo, 32'hFFFF_FFFA);

    issue(MDU_DIVU, 32'd100, 32'd7);
    wait_idle(n);
    chk("divu_lat", 32'(n), 32'd33);
    chk("divu_lo", lo, 32'h0000_000E);
    chk("divu_hi", hi, 32'h0000_0002);

    issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    chk("div_neg_lo", lo, 32'hFFFF_FFFD);
    chk("div_neg_hi", hi, 32'hFFFF_FFFF);

    issue(MDU_DIVU, 32'h0000_1234, 32'd0);
    wait_idle(n);
    chk("divu0_lo", lo, 32'hFFFF_FFFF);
    chk("divu0_hi", hi, 32'h0000_1234);

    issue(MDU_DIV, 32'hFFFF_FF00, 32'd0);
    wait_idle(n);
    chk("div0_lo", lo, 32'hFFFF_FFFF);
    chk("div0_hi", hi, 32'hFFFF_FF00);

    issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    chk("divmin_lo", lo, 32'h8000_0000);
    chk("divmin_hi", hi, 32'h0000_0000);

    // start under req is flushed
    @(negedge clk);
    op = MDU_MULT; in_a = 32'd7; in_b = 32'd7; start = 1'b1; req = 1'b1;
    @(negedge clk);
    start = 1'b0; req = 1'b0;
    chk("req_busy", {31'b0, busy}, 32'h0);
    @(negedge clk);
    chk("req_busy2", {31'b0, busy}, 32'h0);
    chk("req_lo", lo, 32'h8000_0000);
    chk("req_hi", hi, 32'h0000_0000);

    // mthi and mtlo together
    @(negedge clk);
    mthi = 1'b1; mtlo = 1'b1; data_w = 32'h0000_5A5A;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    chk("mtboth_hi", hi, 32'h0000_5A5A);
    chk("mtboth_lo", lo, 32'h0000_5A5A);

    // mthi while busy is dropped
    issue(MDU_MULT, 32'd3, 32'd4);
    mthi = 1'b1; data_w = 32'h0000_DEAD;
    @(negedge clk);
    mthi = 1'b0;
    wait_idle(n);
    chk("mthi_busy_lat", 32'(n), 32'd4);
    chk("mthi_busy_hi", hi, 32'h0000_0000);
    chk("mthi_busy_lo", lo, 32'h0000_000C);

    // start beats a same-cycle mtlo
    @(negedge clk);
    op = MDU_MULT; in_a = 32'd2; in_b = 32'd2; start = 1'b1; mtlo = 1'b1; data_w = 32'h99;
    @(negedge clk);
    start = 1'b0; mtlo = 1'b0;
    wait_idle(n);
    chk("start_mtlo_lat", 32'(n), 32'd5);
    chk("start_mtlo_lo", lo, 32'h0000_0004);

`ifdef MDU_ACC_EN
    @(negedge clk);
    mtlo = 1'b1; data_w = 32'd10;
    @(negedge clk);
    mtlo = 1'b0; mthi = 1'b1; data_w = 32'd0;
    @(negedge clk);
    mthi = 1'b0;
    issue(MDU_MADD, 32'd3, 32'd4);
    wait_idle(n);
    chk("madd_lat", 32'(n), 32'd5);
    chk("madd_lo", lo, 32'h0000_0016);
    chk("madd_hi", hi, 32'h0000_0000);
    issue(MDU_MSUBU, 32'd1, 32'h17);
    wait_idle(n);
    chk("msubu_hi", hi, 32'hFFFF_FFFF);
    chk("msubu_lo", lo, 32'hFFFF_FFFF);
`else
    issue(MDU_MADD, 32'd3, 32'd4);
    chk("acc_off_busy", {31'b0, busy}, 32'h0);
    repeat (2) @(negedge clk);
    chk("acc_off_lo", lo, 32'h0000_0004);
    chk("acc_off_hi", hi, 32'h0000_0000);
`endif

    // reset during the 10th busy cycle of a divide
    issue(MDU_DIVU, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    chk("middiv_busy", {31'b0, busy}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_div_busy", {31'b0, busy}, 32'h0);
    chk("rst_div_hi", hi, 32'h0);
    chk("rst_div_lo", lo, 32'h0);
    repeat (40) @(negedge clk);
    chk("rst_div_nocommit", lo, 32'h0);

    issue(MDU_MULT, 32'd5, 32'd6);
    wait_idle(n);
    chk("post_rst_lat", 32'(n), 32'd5);
    chk("post_rst_lo", lo, 32'h0000_001E);
    chk("post_rst_hi", hi, 32'h0000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
